// File: rtl/alu_pkg.sv
// Shared opcode constants and flag layout for the pipelined ALU.
package alu_pkg;

    localparam int LEN_OP_DEF = 6;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SLL = 6'b000000;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 2;
    localparam int FLAG_INV   = 3;
    localparam int N_FLAGS    = 4;

    typedef logic [N_FLAGS-1:0] flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and zero/carry/overflow/invalid flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int LEN_DATO = 8,
    parameter int LEN_OP   = LEN_OP_DEF
) (
    input  logic [LEN_DATO-1:0] a,
    input  logic [LEN_DATO-1:0] b,
    input  logic [LEN_OP-1:0]   op,
    output logic [LEN_DATO-1:0] result,
    output flags_t              flags
);

    localparam int M = LEN_DATO - 1;

    logic [LEN_DATO:0] sum;
    logic [LEN_DATO:0] diff;
    logic              big;
    logic              carry;
    logic              ovf;
    logic              inv;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    // Shift amounts at or beyond the width saturate explicitly.
    assign big  = (b >= LEN_DATO'(LEN_DATO));

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        inv    = 1'b0;
        unique case (1'b1)
            (op == LEN_OP'(OP_ADD)): begin
                result = sum[M:0];
                carry  = sum[LEN_DATO];
                ovf    = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            (op == LEN_OP'(OP_SUB)): begin
                result = diff[M:0];
                carry  = diff[LEN_DATO];
                ovf    = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            (op == LEN_OP'(OP_AND)): result = a & b;
            (op == LEN_OP'(OP_OR)):  result = a | b;
            (op == LEN_OP'(OP_XOR)): result = a ^ b;
            (op == LEN_OP'(OP_NOR)): result = ~(a | b);
            (op == LEN_OP'(OP_SRL)): result = big ? '0 : (a >> b);
            (op == LEN_OP'(OP_SRA)): begin
                result = big ? {LEN_DATO{a[M]}}
                             : LEN_DATO'($signed(a) >>> b);
            end
            (op == LEN_OP'(OP_SLL)): result = big ? '0 : (a << b);
            default: inv = 1'b1;
        endcase
    end

    always_comb begin
        flags             = '0;
        flags[FLAG_ZERO]  = !inv && (result == '0);
        flags[FLAG_CARRY] = carry;
        flags[FLAG_OVF]   = ovf;
        flags[FLAG_INV]   = inv;
    end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined ALU: combinational core feeding N_STAGES registered stages
// that advance together unless the output is held by the consumer.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int LEN_DATO = 8,
    parameter int LEN_OP   = LEN_OP_DEF,
    parameter int N_STAGES = 2
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [LEN_DATO-1:0] i_dato_a,
    input  logic [LEN_DATO-1:0] i_dato_b,
    input  logic [LEN_OP-1:0]   i_op_code,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [LEN_DATO-1:0] o_resultado,
    output logic                o_zero,
    output logic                o_carry,
    output logic                o_overflow,
    output logic                o_invalid_op
);

    logic [LEN_DATO-1:0] core_res;
    flags_t              core_flg;

    logic [N_STAGES-1:0]               vld;
    logic [N_STAGES-1:0][LEN_DATO-1:0] res;
    flags_t [N_STAGES-1:0]             flg;

    logic stall;

    alu_core #(
        .LEN_DATO (LEN_DATO),
        .LEN_OP   (LEN_OP)
    ) u_core (
        .a      (i_dato_a),
        .b      (i_dato_b),
        .op     (i_op_code),
        .result (core_res),
        .flags  (core_flg)
    );

    // A held result freezes the whole pipe; bubbles are not squeezed out.
    assign stall   = vld[N_STAGES-1] && !i_ready;
    assign o_ready = !stall;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            vld <= '0;
            res <= '0;
            flg <= '0;
        end else if (!stall) begin
            vld[0] <= i_valid;
            res[0] <= core_res;
            flg[0] <= core_flg;
            for (int s = 1; s < N_STAGES; s++) begin
                vld[s] <= vld[s-1];
                res[s] <= res[s-1];
                flg[s] <= flg[s-1];
            end
        end
    end

    assign o_valid      = vld[N_STAGES-1];
    assign o_resultado  = res[N_STAGES-1];
    assign o_zero       = flg[N_STAGES-1][FLAG_ZERO];
    assign o_carry      = flg[N_STAGES-1][FLAG_CARRY];
    assign o_overflow   = flg[N_STAGES-1][FLAG_OVF];
    assign o_invalid_op = flg[N_STAGES-1][FLAG_INV];

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: three instances (1, 2 and 4 stages)
// exercised one at a time through a shared driver and scoreboard.
module tb_alu_pipe;

    typedef struct packed {
        logic [7:0] r;
        logic [3:0] f;
    } exp_t;

    typedef struct {
        logic [5:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [3:0] f;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vin = 1'b0;
    logic       rdy = 1'b1;
    logic [7:0] t_a = '0;
    logic [7:0] t_b = '0;
    logic [5:0] t_op = '0;
    int         sel = 1;
    exp_t       cur_exp = '0;

    logic       ov   [3];
    logic       ordy [3];
    logic [7:0] ores [3];
    logic       oz   [3];
    logic       oc   [3];
    logic       oo   [3];
    logic       oi   [3];

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   stall_cnt = 0;

    always #5 clk = ~clk;

    alu_pipe #(.LEN_DATO(8), .LEN_OP(6), .N_STAGES(1)) dut1 (
        .i_clock(clk), .i_reset(rst), .i_valid(vin && sel == 0),
        .o_ready(ordy[0]), .i_dato_a(t_a), .i_dato_b(t_b),
        .i_op_code(t_op), .o_valid(ov[0]), .i_ready(rdy),
        .o_resultado(ores[0]), .o_zero(oz[0]), .o_carry(oc[0]),
        .o_overflow(oo[0]), .o_invalid_op(oi[0])
    );

    alu_pipe #(.LEN_DATO(8), .LEN_OP(6), .N_STAGES(2)) dut2 (
        .i_clock(clk), .i_reset(rst), .i_valid(vin && sel == 1),
        .o_ready(ordy[1]), .i_dato_a(t_a), .i_dato_b(t_b),
        .i_op_code(t_op), .o_valid(ov[1]), .i_ready(rdy),
        .o_resultado(ores[1]), .o_zero(oz[1]), .o_carry(oc[1]),
        .o_overflow(oo[1]), .o_invalid_op(oi[1])
    );

    alu_pipe #(.LEN_DATO(8), .LEN_OP(6), .N_STAGES(4)) dut4 (
        .i_clock(clk), .i_reset(rst), .i_valid(vin && sel == 2),
        .o_ready(ordy[2]), .i_dato_a(t_a), .i_dato_b(t_b),
        .i_op_code(t_op), .o_valid(ov[2]), .i_ready(rdy),
        .o_resultado(ores[2]), .o_zero(oz[2]), .o_carry(oc[2]),
        .o_overflow(oo[2]), .o_invalid_op(oi[2])
    );

    function automatic int nst(input int s);
        return (s == 0) ? 1 : (s == 1) ? 2 : 4;
    endfunction

    // Reference model; flags packed as {invalid, overflow, carry, zero}.
    function automatic exp_t model(input logic [5:0] op,
                                   input logic [7:0] a,
                                   input logic [7:0] b);
        exp_t e;
        int ua, ub, sa, sb, u, s;
        logic c, v, inv;
        ua = int'(a);
        ub = int'(b);
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        c = 1'b0;
        v = 1'b0;
        inv = 1'b0;
        e.r = 8'h00;
        case (op)
            6'b100000: begin
                u = ua + ub; s = sa + sb;
                e.r = 8'(u); c = (u > 255); v = (s > 127 || s < -128);
            end
            6'b100010: begin
                u = ua - ub; s = sa - sb;
                e.r = 8'(u); c = (ua < ub); v = (s > 127 || s < -128);
            end
            6'b100100: e.r = a & b;
            6'b100101: e.r = a | b;
            6'b100110: e.r = a ^ b;
            6'b100111: e.r = ~(a | b);
            6'b000010: e.r = (ub >= 8) ? 8'h00 : 8'(ua / (1 << ub));
            6'b000000: e.r = (ub >= 8) ? 8'h00 : 8'(ua * (1 << ub));
            6'b000011: begin
                if (ub >= 8) e.r = a[7] ? 8'hFF : 8'h00;
                else e.r = 8'((sa - ((sa % (1 << ub) + (1 << ub)) % (1 << ub))) / (1 << ub));
            end
            default: inv = 1'b1;
        endcase
        e.f = {inv, v, c, !inv && e.r == 8'h00};
        return e;
    endfunction

    // Scoreboard: expectations queued on input transfer, checked on output.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t got;
            got = {ores[sel], oi[sel], oo[sel], oc[sel], oz[sel]};
            if (ov[sel]) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_valid n=%0d got=%h expected none",
                             nst(sel), got);
                end else begin
                    if (got !== q[0]) begin
                        failures++;
                        $display("FAIL result n=%0d got=%h required=%h stalled=%0d",
                                 nst(sel), got, q[0], !rdy);
                    end
                    if (rdy) void'(q.pop_front());
                    else stall_cnt++;
                end
            end
            checks++;
            if (ordy[sel] !== !(ov[sel] && !rdy)) begin
                failures++;
                $display("FAIL o_ready n=%0d got=%b required=%b",
                         nst(sel), ordy[sel], !(ov[sel] && !rdy));
            end
            if (vin && ordy[sel]) q.push_back(cur_exp);
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s n=%0d got=%h required=%h", name, nst(sel), got, req);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [5:0] op, input logic [7:0] a,
                        input logic [7:0] b, input exp_t e);
        int guard;
        t_op = op; t_a = a; t_b = b; cur_exp = e; vin = 1'b1;
        @(negedge clk);
        guard = 0;
        while (!ordy[sel] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            failures++;
            $display("FAIL accept_timeout n=%0d", nst(sel));
        end
        @(posedge clk); #1;
        vin = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; vin = 1'b0; rdy = 1'b1;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {ov[sel], ores[sel], oz[sel], oc[sel], oo[sel], oi[sel]}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", ordy[sel], 1);
    endtask

    task automatic stream6();
        logic [5:0] ops [10];
        ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                6'b100111, 6'b000010, 6'b000011, 6'b000000, 6'b101010};
        for (int i = 0; i < 6; i++) begin
            logic [5:0] op;
            logic [7:0] a, b;
            op = ops[$urandom_range(0, 9)];
            a = 8'($urandom);
            b = (op[5] == 1'b0) ? 8'($urandom_range(0, 11)) : 8'($urandom);
            send(op, a, b, model(op, a, b));
        end
    endtask

    vec_t tbl [17];

    initial begin
        int cnt;
        tbl = '{
            '{6'b100000, 8'h7F, 8'h01, 8'h80, 4'b0100},
            '{6'b100000, 8'hFF, 8'h01, 8'h00, 4'b0011},
            '{6'b100010, 8'h05, 8'h05, 8'h00, 4'b0001},
            '{6'b100010, 8'h80, 8'h01, 8'h7F, 4'b0100},
            '{6'b100010, 8'h01, 8'h02, 8'hFF, 4'b0010},
            '{6'b000011, 8'hA0, 8'h02, 8'hE8, 4'b0000},
            '{6'b000010, 8'hA0, 8'h01, 8'h50, 4'b0000},
            '{6'b000011, 8'hA0, 8'h09, 8'hFF, 4'b0000},
            '{6'b000000, 8'h81, 8'h01, 8'h02, 4'b0000},
            '{6'b100111, 8'h08, 8'h10, 8'hE7, 4'b0000},
            '{6'b111111, 8'h12, 8'h34, 8'h00, 4'b1000},
            '{6'b100000, 8'h01, 8'h02, 8'h03, 4'b0000},
            '{6'b100100, 8'hF0, 8'h3C, 8'h30, 4'b0000},
            '{6'b100101, 8'hF0, 8'h3C, 8'hFC, 4'b0000},
            '{6'b100110, 8'hF0, 8'h3C, 8'hCC, 4'b0000},
            '{6'b000010, 8'h80, 8'h08, 8'h00, 4'b0001},
            '{6'b000000, 8'h01, 8'h07, 8'h80, 4'b0000}
        };

        for (int s = 0; s < 3; s++) begin
            sel = s;
            do_reset();

            send(6'b100000, 8'h7F, 8'h01, exp_t'({8'h80, 4'b0100}));
            cnt = 1;
            @(negedge clk);
            while (!ov[sel] && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            chk("latency", cnt, nst(sel));
            @(posedge clk); #1;
            drain();

            foreach (tbl[i])
                send(tbl[i].op, tbl[i].a, tbl[i].b, exp_t'({tbl[i].r, tbl[i].f}));
            drain();

            stall_cnt = 0;
            fork
                stream6();
                begin
                    repeat (nst(sel) + 1) @(posedge clk);
                    #1 rdy = 1'b0;
                    repeat (3) @(posedge clk);
                    #1 rdy = 1'b1;
                end
            join
            drain();
            chk("stall_cycles", stall_cnt, 3);
        end

        sel = 1;
        do_reset();
        rdy = 1'b0;
        send(6'b100000, 8'h10, 8'h20, exp_t'({8'h30, 4'b0000}));
        send(6'b100010, 8'h10, 8'h20, exp_t'({8'hF0, 4'b0010}));
        #3 rst = 1'b1;
        #1 chk("rst_async_valid", ov[sel], 0);
        chk("rst_async_res", ores[sel], 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_stale", ov[sel], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
